mul_add_sched: RTL and testbench
================================

# mul_add_sched

Round-robin scheduler that shares one pipelined floating-point multiplier (`fp_mul`) and one pipelined floating-point adder (`add`) among `NUM_REQ` requesters. Each requester computes `result = a*b + c`. The block keeps both cores streaming at one issue per cycle. It tracks each operation's owner through a tag pipeline and returns each result to its owner with a one-cycle `done` pulse. It sits between the CORDIC iteration units and the FP cores, replacing per-unit counter-based sequencing.

## Interface

Parameters:
- `DATA_WIDTH`, 32, IEEE-754 single operand/result width
- `NUM_REQ`, 4, number of requesters, 2..8
- `MUL_LATENCY`, 5, `fp_mul` pipeline depth in cycles, ≥1
- `ADD_LATENCY`, 7, `add` pipeline depth in cycles, ≥1

Ports:
- `clk`  in  1  single clock for the block and both cores
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_REQ  per-requester operation request; held until `gnt`
- `req_a`, `req_b`, `req_c`  in  NUM_REQ*DATA_WIDTH  flattened operands; slice k belongs to requester k
- `gnt`  out  NUM_REQ  one-hot, one-cycle accept pulse
- `busy`  out  NUM_REQ  requester has an operation in flight
- `core_aclr`  out  1  `~rst_n`, drives the `aclr` input of both cores
- `core_en`  out  1  `clk_en` for both cores
- `mul_a`, `mul_b`  out  DATA_WIDTH  registered multiplier operands
- `mul_result`  in  DATA_WIDTH  from `fp_mul`
- `add_a`, `add_b`  out  DATA_WIDTH  adder operands
- `add_result`  in  DATA_WIDTH  from `add`
- `result`  out  DATA_WIDTH  registered result
- `done`  out  NUM_REQ  one-hot, one-cycle result-valid pulse

## Operation

- **Eligibility:** requester k is eligible when `req[k] & ~busy[k]`. Each requester has at most one operation outstanding.
- **Arbitration:** round-robin with a `last` pointer. Search starts at `last+1` and wraps modulo `NUM_REQ`. At most one grant per cycle. `last` updates only when a grant is issued.
- **On grant k (edge E):**
  - `mul_a <= a_k`, `mul_b <= b_k`
  - `busy[k] <= 1`
  - the tag pipe, `MUL_LATENCY+ADD_LATENCY+1` stages, shifts in `{valid=1, owner=k}`
  - the c-pipe, `MUL_LATENCY+1` stages, shifts in `c_k`
- **No grant:** the tag pipe shifts in `valid=0`. The mul operands hold their values; the result is discarded because of the invalid tag.
- **Adder operands:** `add_a = mul_result` and `add_b = c-pipe tail`, both combinational.
- **Tag pipe output:** when the tail is valid with owner k:
  - `result <= add_result`
  - `done[k] <= 1` for one cycle
  - `busy[k] <= 0`, on the same edge
- **Done/request overlap:** in the cycle where `done[k]=1`, `busy[k]` is already 0. Requester k is therefore eligible and may be granted in that same cycle.
- **Core enable:** `core_en = rst_n`. The cores are never stalled, so latency is deterministic.
- **Reset (async, including mid-operation):** `gnt`, `busy`, `done`, `mul_a`, `mul_b`, `result`, tag valids and c-pipe all go to 0. `last` goes to `NUM_REQ-1`, so requester 0 has first priority. In-flight operations are dropped silently and produce no `done`.
- **Arithmetic:** the block performs no arithmetic; all FP work is in the cores.

## Timing

- `gnt` is combinational from `req`, `busy` and `last`.
- Request accepted in cycle t (`req[k] & gnt[k]`):
  - `mul_a`/`mul_b` valid in cycle t+1
  - `mul_result` in cycle t+1+MUL_LATENCY
  - `add_result` in cycle t+1+MUL_LATENCY+ADD_LATENCY
  - `result`/`done[k]` in cycle t+2+MUL_LATENCY+ADD_LATENCY, which is t+14 with defaults
- Throughput: one issue per cycle across requesters; one per requester per round-trip latency.
- Results return in issue order.
- Requesters must hold `req` and operands stable until `gnt`. Dropping `req` before `gnt` withdraws the request without side effects.

## Structure

- **Package `mul_add_pkg`:** `DATA_WIDTH`, default latencies, `NUM_REQ`, `TAG_WIDTH = $clog2(NUM_REQ)`, and the tag record type `{valid, owner}`.
- **Sub-module `rr_arbiter`:** parameterised `NUM_REQ`; inputs are the eligible vector and `advance`; outputs are the one-hot grant and the `last` pointer.
- **Top-level:** `mul_add_sched` contains the operand registers, tag pipe, c-pipe, busy vector and result register.
- The cores are instantiated by the parent, not inside this block.

## Test plan

- **Single op:** requester 0 sends a=0x40000000 (2.0), b=0x40400000 (3.0), c=0x3F800000 (1.0). Expect `gnt[0]` in the same cycle, `busy[0]=1`, then `done[0]` and `result=0x40E00000` (7.0) exactly 14 cycles later, with `busy[0]=0`.
- **All four request every cycle from reset:** grants go 0,1,2,3 on consecutive cycles. Then none are granted until each requester's `done` frees it. Each requester is re-granted in its own `done` cycle.
- **Round-robin fairness:** with `last=1`, assert `req` on 0 and 3 together. `gnt[3]` is issued first, then `gnt[0]` on the next cycle.
- **Back-to-back distinct operands:** 4 ops issued on consecutive cycles each carry a unique c (1.0, 2.0, 3.0, 4.0) with a=b=0. Results 1.0–4.0 appear on 4 consecutive cycles with the matching one-hot `done`.
- **Reset mid-flight:** assert `rst_n=0` 6 cycles after a grant. All outputs read 0 immediately, and no `done` appears within 20 cycles after release. The first post-reset request goes to requester 0.
- **Request withdrawal:** requester 2's `req` is high for 1 cycle while `busy[2]=1`, then dropped. No grant is issued and no state changes.

Source files
------------

// File: rtl/mul_add_pkg.sv
//------------------------------------------------------------------------------
// Module   : mul_add_pkg
// Purpose  : Shared widths, default core latencies and tag record for mul_add_sched.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mul_add_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int NUM_REQ     = 4;
    localparam int MUL_LATENCY = 5;
    localparam int ADD_LATENCY = 7;
    localparam int TAG_WIDTH   = $clog2(NUM_REQ);

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] owner;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/mul_add_sched_if.sv
//------------------------------------------------------------------------------
// Module   : mul_add_sched_if
// Purpose  : Requester and FP-core signal bundle for mul_add_sched.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mul_add_sched_if #(
    parameter int DATA_WIDTH = mul_add_pkg::DATA_WIDTH,
    parameter int NUM_REQ    = mul_add_pkg::NUM_REQ
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_c;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            busy;
    logic                          core_aclr;
    logic                          core_en;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;
    logic [DATA_WIDTH-1:0]         mul_result;
    logic [DATA_WIDTH-1:0]         add_a;
    logic [DATA_WIDTH-1:0]         add_b;
    logic [DATA_WIDTH-1:0]         add_result;
    logic [DATA_WIDTH-1:0]         result;
    logic [NUM_REQ-1:0]            done;

    // Scheduler side
    modport master (
        input  req, req_a, req_b, req_c, mul_result, add_result,
        output gnt, busy, core_aclr, core_en, mul_a, mul_b, add_a, add_b, result, done
    );

    // Requesters and FP cores
    modport slave (
        output req, req_a, req_b, req_c, mul_result, add_result,
        input  gnt, busy, core_aclr, core_en, mul_a, mul_b, add_a, add_b, result, done
    );

endinterface

`default_nettype wire

// File: rtl/mul_add_sched_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Round-robin one-hot arbiter; search starts after the last winner.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int c_idx_w = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [c_idx_w-1:0] last
);

    logic [c_idx_w-1:0] r_last;
    logic [c_idx_w-1:0] w_idx;
    logic [c_idx_w-1:0] w_win_idx;

    // Walk from the farthest candidate back to last+1 so the nearest eligible one wins.
    always_comb begin
        grant     = '0;
        w_idx     = '0;
        w_win_idx = r_last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = c_idx_w'((int'(r_last) + i) % NUM_REQ);
            if (eligible[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                w_win_idx    = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= c_idx_w'(NUM_REQ - 1);
        end else if (advance) begin
            r_last <= w_win_idx;
        end
    end

    assign last = r_last;

endmodule

`default_nettype wire

// File: rtl/mul_add_sched.sv
//------------------------------------------------------------------------------
// Module   : mul_add_sched
// Purpose  : Shares one pipelined FP multiplier and adder among NUM_REQ requesters (a*b+c).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_add_sched #(
    parameter int DATA_WIDTH  = mul_add_pkg::DATA_WIDTH,
    parameter int NUM_REQ     = mul_add_pkg::NUM_REQ,
    parameter int MUL_LATENCY = mul_add_pkg::MUL_LATENCY,
    parameter int ADD_LATENCY = mul_add_pkg::ADD_LATENCY
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_add_sched_if.master  bus
);

    import mul_add_pkg::*;

    localparam int c_tag_depth = MUL_LATENCY + ADD_LATENCY + 1;
    localparam int c_c_depth   = MUL_LATENCY + 1;
    localparam int c_idx_w     = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    w_eligible;
    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    w_retire;
    logic [c_idx_w-1:0]    w_last;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_a_sel;
    logic [DATA_WIDTH-1:0] w_b_sel;
    logic [DATA_WIDTH-1:0] w_c_sel;
    tag_t                  w_tag_head;
    tag_t                  w_tag_tail;

    logic                  r_issue;
    logic [NUM_REQ-1:0]    r_busy;
    logic [NUM_REQ-1:0]    r_done;
    logic [DATA_WIDTH-1:0] r_mul_a;
    logic [DATA_WIDTH-1:0] r_mul_b;
    logic [DATA_WIDTH-1:0] r_result;
    tag_t                  r_tag_pipe [c_tag_depth-1];
    logic [DATA_WIDTH-1:0] r_c_pipe   [c_c_depth];

    assign w_eligible = bus.req & ~r_busy & {NUM_REQ{rst_n}};
    assign w_issue    = |w_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (w_eligible),
        .advance  (w_issue),
        .grant    (w_grant),
        .last     (w_last)
    );

    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        w_c_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_a_sel = bus.req_a[k*DATA_WIDTH +: DATA_WIDTH];
                w_b_sel = bus.req_b[k*DATA_WIDTH +: DATA_WIDTH];
                w_c_sel = bus.req_c[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The arbiter pointer moves only on a grant, so one cycle after an issue it
    // names that issue's owner; together with r_issue it forms tag stage 0.
    always_comb begin
        w_tag_head.valid = r_issue;
        w_tag_head.owner = TAG_WIDTH'(w_last);
    end

    assign w_tag_tail = r_tag_pipe[c_tag_depth-2];

    always_comb begin
        w_retire = '0;
        if (w_tag_tail.valid) begin
            w_retire[w_tag_tail.owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue  <= 1'b0;
            r_busy   <= '0;
            r_done   <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_result <= '0;
            for (int i = 0; i < c_tag_depth - 1; i++) begin
                r_tag_pipe[i] <= '0;
            end
            for (int i = 0; i < c_c_depth; i++) begin
                r_c_pipe[i] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_mul_a <= w_a_sel;
                r_mul_b <= w_b_sel;
            end
            r_issue       <= w_issue;
            r_tag_pipe[0] <= w_tag_head;
            for (int i = 1; i < c_tag_depth - 1; i++) begin
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
            r_c_pipe[0] <= w_c_sel;
            for (int i = 1; i < c_c_depth; i++) begin
                r_c_pipe[i] <= r_c_pipe[i-1];
            end
            r_busy <= (r_busy & ~w_retire) | w_grant;
            r_done <= w_retire;
            if (w_tag_tail.valid) begin
                r_result <= bus.add_result;
            end
        end
    end

    assign bus.gnt       = w_grant;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.add_a     = bus.mul_result;
    assign bus.add_b     = r_c_pipe[c_c_depth-1];
    assign bus.core_aclr = ~rst_n;
    assign bus.core_en   = rst_n;

endmodule

`default_nettype wire

// File: tb/tb_mul_add_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_mul_add_sched
// Purpose  : Directed self-checking bench for mul_add_sched with small FP core models.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_add_sched;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int ML = 5;
    localparam int AL = 7;

    localparam logic [31:0] F0 = 32'h0000_0000;
    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] F6 = 32'h40C0_0000;
    localparam logic [31:0] F7 = 32'h40E0_0000;
    localparam logic [31:0] FBAD = 32'hDEAD_BEEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    mul_add_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    mul_add_sched #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (NR),
        .MUL_LATENCY (ML),
        .ADD_LATENCY (AL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Table-driven stand-ins for the FP cores, covering only the operands used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a == F0 || b == F0) return F0;
        if (a == F1) return b;
        if (b == F1) return a;
        if (a == F2 && b == F3) return F6;
        return FBAD;
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == F0) return b;
        if (b == F0) return a;
        if (a == F6 && b == F1) return F7;
        return FBAD;
    endfunction

    logic [31:0] r_mul_pipe [ML];
    logic [31:0] r_add_pipe [AL];

    always_ff @(posedge clk or posedge bus.core_aclr) begin
        if (bus.core_aclr) begin
            for (int i = 0; i < ML; i++) r_mul_pipe[i] <= '0;
            for (int i = 0; i < AL; i++) r_add_pipe[i] <= '0;
        end else if (bus.core_en) begin
            r_mul_pipe[0] <= fmul(bus.mul_a, bus.mul_b);
            for (int i = 1; i < ML; i++) r_mul_pipe[i] <= r_mul_pipe[i-1];
            r_add_pipe[0] <= fadd(bus.add_a, bus.add_b);
            for (int i = 1; i < AL; i++) r_add_pipe[i] <= r_add_pipe[i-1];
        end
    end

    assign bus.mul_result = r_mul_pipe[ML-1];
    assign bus.add_result = r_add_pipe[AL-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; checks happen 2ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
        bus.req_a[k*DW +: DW] = a;
        bus.req_b[k*DW +: DW] = b;
        bus.req_c[k*DW +: DW] = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    logic [31:0] cv [4];
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_done;
    logic [3:0]  seen;

    initial begin
        cv[0] = F1; cv[1] = F2; cv[2] = F3; cv[3] = F4;
        bus.req   = 4'hF;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;

        // Reset state, with all requests raised to show grants are blocked
        repeat (2) @(posedge clk);
        #3;
        check("rst_gnt",  bus.gnt,       4'h0);
        check("rst_busy", bus.busy,      4'h0);
        check("rst_done", bus.done,      4'h0);
        check("rst_res",  bus.result,    F0);
        check("rst_mula", bus.mul_a,     F0);
        check("rst_aclr", bus.core_aclr, 1'b1);
        check("rst_en",   bus.core_en,   1'b0);
        bus.req = 4'h0;
        next_cycle();
        rst_n = 1'b1;
        #2;
        check("run_en",   bus.core_en,   1'b1);
        check("run_aclr", bus.core_aclr, 1'b0);

        // Single op: 2*3+1 = 7, result 14 cycles after the grant
        next_cycle();
        set_op(0, F2, F3, F1);
        bus.req = 4'b0001;
        #2;
        check("t1_gnt", bus.gnt, 4'b0001);
        next_cycle();
        bus.req = 4'b0000;
        #2;
        check("t1_busy", bus.busy,  4'b0001);
        check("t1_mula", bus.mul_a, F2);
        check("t1_mulb", bus.mul_b, F3);
        seen = '0;
        repeat (12) begin
            next_cycle();
            #2;
            seen |= bus.done;
        end
        check("t1_early_done", seen, 4'h0);
        next_cycle();
        #2;
        check("t1_done", bus.done,   4'b0001);
        check("t1_res",  bus.result, F7);
        check("t1_busy_clr", bus.busy, 4'b0000);
        next_cycle();
        #2;
        check("t1_done_pulse", bus.done, 4'b0000);

        // All four requesting from reset, distinct c, a=b=0
        do_reset();
        next_cycle();
        for (int k = 0; k < 4; k++) set_op(k, F0, F0, cv[k]);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) next_cycle();
            bus.req = (i < 18) ? 4'hF : 4'h0;
            #2;
            exp_gnt  = 4'h0;
            exp_done = 4'h0;
            if (i < 4)               exp_gnt  = 4'b0001 << i;
            if (i >= 14 && i < 18) begin
                exp_gnt  = 4'b0001 << (i - 14);
                exp_done = 4'b0001 << (i - 14);
            end
            if (i >= 28)             exp_done = 4'b0001 << (i - 28);
            check($sformatf("all_gnt_%0d", i), bus.gnt, exp_gnt);
            check($sformatf("all_done_%0d", i), bus.done, exp_done);
            if (exp_done != 4'h0)
                check($sformatf("all_res_%0d", i), bus.result, cv[(i >= 28) ? i - 28 : i - 14]);
            if (i == 4) check("all_busy", bus.busy, 4'hF);
        end

        // Round-robin: last=1, requesters 0 and 3 together -> 3 then 0
        next_cycle();
        set_op(1, F0, F0, F2);
        bus.req = 4'b0010;
        #2;
        check("rr_setup", bus.gnt, 4'b0010);
        next_cycle();
        set_op(0, F0, F0, F1);
        set_op(3, F0, F0, F4);
        bus.req = 4'b1001;
        #2;
        check("rr_first", bus.gnt, 4'b1000);
        next_cycle();
        bus.req = 4'b0001;
        #2;
        check("rr_second", bus.gnt, 4'b0001);
        next_cycle();
        bus.req = 4'b0000;
        repeat (10) next_cycle();
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            #2;
            check($sformatf("rr_done_%0d", j), bus.done,
                  (j == 0) ? 4'b0010 : (j == 1) ? 4'b1000 : 4'b0001);
            check($sformatf("rr_res_%0d", j), bus.result,
                  (j == 0) ? F2 : (j == 1) ? F4 : F1);
        end

        // Withdrawal while busy: no grant, no state change
        next_cycle();
        set_op(2, F2, F3, F1);
        bus.req = 4'b0100;
        #2;
        check("wd_gnt0", bus.gnt, 4'b0100);
        next_cycle();
        set_op(2, F1, F1, F4);
        #2;
        check("wd_gnt", bus.gnt, 4'b0000);
        next_cycle();
        bus.req = 4'b0000;
        #2;
        check("wd_busy", bus.busy,  4'b0100);
        check("wd_mula", bus.mul_a, F2);
        check("wd_mulb", bus.mul_b, F3);
        repeat (11) next_cycle();
        next_cycle();
        #2;
        check("wd_done", bus.done,   4'b0100);
        check("wd_res",  bus.result, F7);

        // Reset mid-flight, six cycles after a grant to requester 2
        next_cycle();
        set_op(2, F2, F3, F1);
        bus.req = 4'b0100;
        #2;
        check("mr_gnt", bus.gnt, 4'b0100);
        next_cycle();
        bus.req = 4'b0000;
        repeat (5) next_cycle();
        #3;
        rst_n   = 1'b0;
        bus.req = 4'b0010;
        #1;
        check("mr_busy", bus.busy,   4'h0);
        check("mr_done", bus.done,   4'h0);
        check("mr_res",  bus.result, F0);
        check("mr_mula", bus.mul_a,  F0);
        check("mr_mulb", bus.mul_b,  F0);
        check("mr_gnt0", bus.gnt,    4'h0);
        check("mr_addb", bus.add_b,  F0);
        next_cycle();
        next_cycle();
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        seen    = '0;
        repeat (20) begin
            next_cycle();
            #2;
            seen |= bus.done;
        end
        check("mr_no_done", seen, 4'h0);
        next_cycle();
        for (int k = 0; k < 4; k++) set_op(k, F0, F0, cv[k]);
        bus.req = 4'hF;
        #2;
        check("mr_first", bus.gnt, 4'b0001);
        next_cycle();
        bus.req = 4'h0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
